// File: rtl/dmem_ctrl.sv
// Data-memory controller between the Memory stage and a single-outstanding backing memory.
// Optional 1-entry posted write buffer with load forwarding, enabled by defining DMEM_WBUF_EN.
module dmem_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReqM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        MemStallM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    STORE = 3'd2,
    DRAIN = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t      state_reg;
  logic [31:0] word_addr;
  logic        ack;
  logic        stall_next;

  // Byte-lane bits are dropped: every access is a whole aligned word.
  assign word_addr = ALUOutM & ~32'h3;
  // An acknowledge only counts while a request is actually outstanding.
  assign ack       = mem_ack & mem_req;

`ifdef DMEM_WBUF_EN
  logic        wb_valid;
  logic [31:0] wb_addr;
  logic [31:0] wb_data;
  logic        is_load;
  logic        is_store;
  logic        wb_hit;

  assign is_load  = MemReqM & ~MemWriteM;
  assign is_store = MemReqM & MemWriteM;
  assign wb_hit   = wb_valid && (wb_addr == word_addr);
`endif

  always_comb begin
    stall_next = 1'b0;
    case (state_reg)
`ifdef DMEM_WBUF_EN
      IDLE:  stall_next = is_load;
      DRAIN: begin
        if (is_store)
          stall_next = ~ack;
        else if (is_load)
          stall_next = ~wb_hit;
      end
`else
      IDLE:  stall_next = MemReqM;
`endif
      LOAD:  stall_next = 1'b1;
      STORE: stall_next = 1'b1;
      default: stall_next = 1'b0;
    endcase
  end

  // Reset must drop the stall immediately, even with a request still presented.
  assign MemStallM = reset & stall_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      ReadDataM <= 32'h0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
`ifdef DMEM_WBUF_EN
      wb_valid  <= 1'b0;
      wb_addr   <= 32'h0;
      wb_data   <= 32'h0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (MemReqM) begin
            mem_req  <= 1'b1;
            mem_we   <= MemWriteM;
            mem_addr <= word_addr;
`ifdef DMEM_WBUF_EN
            if (MemWriteM) begin
              // Post the store and let the pipeline move on.
              wb_valid  <= 1'b1;
              wb_addr   <= word_addr;
              wb_data   <= WriteDataM;
              mem_wdata <= WriteDataM;
              state_reg <= DRAIN;
            end else begin
              state_reg <= LOAD;
            end
`else
            if (MemWriteM) begin
              mem_wdata <= WriteDataM;
              state_reg <= STORE;
            end else begin
              state_reg <= LOAD;
            end
`endif
          end
        end

        LOAD: begin
          if (ack) begin
            ReadDataM <= mem_rdata;
            mem_req   <= 1'b0;
            state_reg <= RESP;
          end
        end

        STORE: begin
          if (ack) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            state_reg <= RESP;
          end
        end

        // One cycle with stall low so the held request is consumed, not reissued.
        RESP: state_reg <= IDLE;

        DRAIN: begin
`ifdef DMEM_WBUF_EN
          if (is_load && wb_hit)
            ReadDataM <= wb_data;
          if (ack) begin
            if (is_store) begin
              // Chain the next write directly behind the completed one.
              wb_addr   <= word_addr;
              wb_data   <= WriteDataM;
              mem_addr  <= word_addr;
              mem_wdata <= WriteDataM;
            end else begin
              wb_valid  <= 1'b0;
              mem_req   <= 1'b0;
              mem_we    <= 1'b0;
              state_reg <= IDLE;
            end
          end
`else
          state_reg <= IDLE;
`endif
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed latency/buffer/reset scenarios plus a random
// load/store stream against an architectural memory model. Define DMEM_WBUF_EN to match the DUT build.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemReqM = 1'b0;
  logic        MemWriteM = 1'b0;
  logic [31:0] ALUOutM = 32'h0;
  logic [31:0] WriteDataM = 32'h0;
  logic [31:0] ReadDataM;
  logic        MemStallM;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  always #5 clk = ~clk;

  dmem_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .MemReqM    (MemReqM),
    .MemWriteM  (MemWriteM),
    .ALUOutM    (ALUOutM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .MemStallM  (MemStallM),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  int vectors = 0;
  int miscompares = 0;

  // Backing memory model: word-indexed, acks a request after cur_lat cycles of mem_req.
  bit [31:0]   bmem [0:255];
  int          req_age = 0;
  int          cur_lat = 1;
  int          mem_lat = 1;
  bit          rand_lat = 1'b0;
  bit          ack_noise = 1'b0;
  bit          inject_ack = 1'b0;
  int          txn_count = 0;
  logic [31:0] wr_log [$];
  logic [31:0] exp_rd = 32'h0;

  task automatic mem_drive();
    if (mem_req === 1'b1) begin
      if (req_age == 0)
        cur_lat = rand_lat ? int'($urandom_range(1, 4)) : mem_lat;
      req_age++;
      mem_ack   = (req_age >= cur_lat);
      mem_rdata = bmem[mem_addr[9:2]];
    end else begin
      req_age   = 0;
      mem_ack   = inject_ack ? 1'b1 : (ack_noise ? 1'($urandom_range(0, 1)) : 1'b0);
      mem_rdata = $urandom;
    end
  endtask

  task automatic mem_commit();
    if (mem_req === 1'b1 && mem_ack === 1'b1) begin
      txn_count++;
      if (mem_we === 1'b1) begin
        bmem[mem_addr[9:2]] = mem_wdata;
        wr_log.push_back(mem_addr);
      end
      req_age = 0;
    end
  endtask

  // One clock cycle: inputs applied 1ns after the rising edge, outputs sampled on the falling edge.
  task automatic run_cycle(input logic req, input logic we, input logic [31:0] addr,
                           input logic [31:0] data, output logic stall, output logic [31:0] rd);
    @(posedge clk);
    #1;
    MemReqM    = req;
    MemWriteM  = we;
    ALUOutM    = addr;
    WriteDataM = data;
    mem_drive();
    @(negedge clk);
    stall = MemStallM;
    rd    = ReadDataM;
    mem_commit();
  endtask

  // Pipeline model: hold the request until the stall drops.
  task automatic do_op(input logic req, input logic we, input logic [31:0] addr,
                       input logic [31:0] data, output int stalls,
                       output logic [31:0] rd_first, output logic [31:0] rd_acc,
                       output logic saw_we);
    logic        st;
    logic [31:0] rd;
    stalls   = 0;
    saw_we   = 1'b0;
    rd_first = 32'h0;
    rd_acc   = 32'h0;
    for (int c = 0; c < 64; c++) begin
      run_cycle(req, we, addr, data, st, rd);
      if (c == 0) rd_first = rd;
      if (mem_req === 1'b1 && mem_we === 1'b1) saw_we = 1'b1;
      if (st !== 1'b1) begin
        rd_acc = rd;
        if (req)
          $display("op %s addr=%08h data=%08h stalls=%0d rd=%08h",
                   we ? "ST" : "LD", addr, data, stalls, rd_acc);
        return;
      end
      stalls++;
    end
    vectors++;
    miscompares++;
    $display("FAIL op_timeout: addr=%08h still stalled after 64 cycles, want acceptance", addr);
  endtask

  task automatic idle(input int n);
    int          s;
    logic [31:0] a, b;
    logic        w;
    for (int i = 0; i < n; i++) do_op(1'b0, 1'b0, 32'h0, 32'h0, s, a, b, w);
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    MemReqM = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    vectors++;
    if (MemStallM !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_stall_gated: got %b, want 0", MemStallM);
    end
    MemReqM = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    vectors++;
    if (ReadDataM !== 32'h0) begin miscompares++; $display("FAIL reset_rdata: got %08h, want 0", ReadDataM); end
    vectors++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0) begin
      miscompares++; $display("FAIL reset_req_we: got %b%b, want 00", mem_req, mem_we);
    end
    vectors++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      miscompares++; $display("FAIL reset_addr_wdata: got %08h/%08h, want 0/0", mem_addr, mem_wdata);
    end
    vectors++;
    if (MemStallM !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %b, want 0", MemStallM); end
    exp_rd = 32'h0;
  endtask

  task automatic test_load_latency();
    int          stalls, t0;
    logic [31:0] rdf, rda;
    logic        sw;
    bmem[32'h100 >> 2] = 32'hCAFEF00D;
    mem_lat = 3;
    t0 = txn_count;
    do_op(1'b1, 1'b0, 32'h100, 32'h0, stalls, rdf, rda, sw);
    vectors++;
    if (stalls != 4) begin miscompares++; $display("FAIL load_stalls: got %0d, want 4", stalls); end
    vectors++;
    if (rda !== 32'hCAFEF00D) begin miscompares++; $display("FAIL load_data: got %08h, want cafef00d", rda); end
    exp_rd = 32'hCAFEF00D;
    do_op(1'b0, 1'b0, 32'h0, 32'h0, stalls, rdf, rda, sw);
    vectors++;
    if (rdf !== exp_rd) begin miscompares++; $display("FAIL load_hold: got %08h, want %08h", rdf, exp_rd); end
    idle(3);
    vectors++;
    if (txn_count - t0 != 1) begin miscompares++; $display("FAIL load_txns: got %0d, want 1", txn_count - t0); end
  endtask

`ifdef DMEM_WBUF_EN
  task automatic test_store_forward();
    int          stalls, t0;
    logic [31:0] rdf, rda;
    logic        sw;
    mem_lat = 2;
    wr_log.delete();
    t0 = txn_count;
    do_op(1'b1, 1'b1, 32'h204, 32'hDEADBEEF, stalls, rdf, rda, sw);
    vectors++;
    if (stalls != 0) begin miscompares++; $display("FAIL fwd_store_stalls: got %0d, want 0", stalls); end
    do_op(1'b1, 1'b0, 32'h204, 32'h0, stalls, rdf, rda, sw);
    vectors++;
    if (stalls != 0) begin miscompares++; $display("FAIL fwd_load_stalls: got %0d, want 0", stalls); end
    do_op(1'b0, 1'b0, 32'h0, 32'h0, stalls, rdf, rda, sw);
    vectors++;
    if (rdf !== 32'hDEADBEEF) begin miscompares++; $display("FAIL fwd_data: got %08h, want deadbeef", rdf); end
    exp_rd = 32'hDEADBEEF;
    idle(5);
    vectors++;
    if (wr_log.size() != 1 || wr_log[0] !== 32'h204 || txn_count - t0 != 1) begin
      miscompares++;
      $display("FAIL fwd_backing: got %0d writes/%0d txns, want one write to 00000204",
               wr_log.size(), txn_count - t0);
    end
  endtask

  task automatic test_back_to_back();
    int          stalls;
    logic [31:0] rdf, rda;
    logic        sw;
    mem_lat = 3;
    wr_log.delete();
    do_op(1'b1, 1'b1, 32'h10, 32'h1111AAAA, stalls, rdf, rda, sw);
    vectors++;
    if (stalls != 0) begin miscompares++; $display("FAIL b2b_first_stalls: got %0d, want 0", stalls); end
    do_op(1'b1, 1'b1, 32'h14, 32'h2222BBBB, stalls, rdf, rda, sw);
    vectors++;
    if (stalls != 2) begin miscompares++; $display("FAIL b2b_second_stalls: got %0d, want 2", stalls); end
    do_op(1'b0, 1'b0, 32'h0, 32'h0, stalls, rdf, rda, sw);
    vectors++;
    if (rdf !== exp_rd) begin miscompares++; $display("FAIL b2b_rdata_hold: got %08h, want %08h", rdf, exp_rd); end
    idle(8);
    vectors++;
    if (wr_log.size() != 2 || wr_log[0] !== 32'h10 || wr_log[1] !== 32'h14) begin
      miscompares++; $display("FAIL b2b_order: got %0d writes, want 00000010 then 00000014", wr_log.size());
    end
    vectors++;
    if (bmem[4] !== 32'h1111AAAA || bmem[5] !== 32'h2222BBBB) begin
      miscompares++; $display("FAIL b2b_data: got %08h/%08h, want 1111aaaa/2222bbbb", bmem[4], bmem[5]);
    end
  endtask

  task automatic test_store_on_ack();
    int          stalls;
    logic [31:0] rdf, rda;
    logic        sw;
    mem_lat = 2;
    wr_log.delete();
    do_op(1'b1, 1'b1, 32'h20, 32'h0C0C0C0C, stalls, rdf, rda, sw);
    do_op(1'b0, 1'b0, 32'h0, 32'h0, stalls, rdf, rda, sw);
    do_op(1'b1, 1'b1, 32'h24, 32'h0D0D0D0D, stalls, rdf, rda, sw);
    vectors++;
    if (stalls != 0) begin miscompares++; $display("FAIL onack_stalls: got %0d, want 0", stalls); end
    do_op(1'b0, 1'b0, 32'h0, 32'h0, stalls, rdf, rda, sw);
    vectors++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h24 || mem_wdata !== 32'h0D0D0D0D) begin
      miscompares++;
      $display("FAIL onack_issue: got req=%b we=%b addr=%08h wdata=%08h, want 1 1 00000024 0d0d0d0d",
               mem_req, mem_we, mem_addr, mem_wdata);
    end
    idle(6);
    vectors++;
    if (wr_log.size() != 2 || wr_log[0] !== 32'h20 || wr_log[1] !== 32'h24) begin
      miscompares++; $display("FAIL onack_order: got %0d writes, want 00000020 then 00000024", wr_log.size());
    end
  endtask
`else
  task automatic test_store_nowbuf();
    int          stalls;
    logic [31:0] rdf, rda;
    logic        sw;
    mem_lat = 1;
    do_op(1'b1, 1'b1, 32'h8, 32'h12345678, stalls, rdf, rda, sw);
    vectors++;
    if (stalls != 2) begin miscompares++; $display("FAIL nowbuf_stalls: got %0d, want 2", stalls); end
    vectors++;
    if (sw !== 1'b1) begin miscompares++; $display("FAIL nowbuf_we: got %b, want 1", sw); end
    vectors++;
    if (rda !== exp_rd) begin miscompares++; $display("FAIL nowbuf_rdata: got %08h, want %08h", rda, exp_rd); end
    idle(2);
    vectors++;
    if (bmem[2] !== 32'h12345678) begin miscompares++; $display("FAIL nowbuf_write: got %08h, want 12345678", bmem[2]); end
  endtask
`endif

  task automatic test_reset_mid_load();
    int          stalls, t0;
    logic        st, sw;
    logic [31:0] rd, rdf, rda;
    mem_lat = 10;
    run_cycle(1'b1, 1'b0, 32'h40, 32'h0, st, rd);
    run_cycle(1'b1, 1'b0, 32'h40, 32'h0, st, rd);
    reset = 1'b0;
    #1;
    vectors++;
    if (mem_req !== 1'b0 || MemStallM !== 1'b0) begin
      miscompares++; $display("FAIL midload_reset: got req=%b stall=%b, want 0 0", mem_req, MemStallM);
    end
    MemReqM = 1'b0;
    mem_ack = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset  = 1'b1;
    exp_rd = 32'h0;
    t0 = txn_count;
    inject_ack = 1'b1;
    run_cycle(1'b0, 1'b0, 32'h0, 32'h0, st, rd);
    inject_ack = 1'b0;
    run_cycle(1'b0, 1'b0, 32'h0, 32'h0, st, rd);
    vectors++;
    if (mem_req !== 1'b0 || st !== 1'b0 || rd !== 32'h0 || txn_count != t0) begin
      miscompares++;
      $display("FAIL late_ack: got req=%b stall=%b rd=%08h txns=%0d, want 0 0 00000000 0",
               mem_req, st, rd, txn_count - t0);
    end
    mem_lat = 1;
    do_op(1'b1, 1'b0, 32'h100, 32'h0, stalls, rdf, rda, sw);
    vectors++;
    if (stalls != 2 || rda !== bmem[32'h100 >> 2]) begin
      miscompares++;
      $display("FAIL post_reset_load: got stalls=%0d data=%08h, want 2 %08h", stalls, rda, bmem[32'h100 >> 2]);
    end
    exp_rd = bmem[32'h100 >> 2];
    idle(2);
  endtask

  task automatic test_random();
    bit [31:0]   ref_mem [0:255];
    int          stalls, kind;
    logic [7:0]  w;
    logic [31:0] addr, data, rdf, rda;
    logic        sw, req, we;
    ref_mem   = bmem;
    rand_lat  = 1'b1;
    ack_noise = 1'b1;
    for (int i = 0; i < 300; i++) begin
      kind = int'($urandom_range(0, 9));
      w    = 8'hC0 + 8'($urandom_range(0, 7));
      addr = {22'h0, w, 2'($urandom)};
      data = $urandom;
      req  = (kind >= 3);
      we   = (kind >= 3 && kind <= 6);
      do_op(req, we, addr, data, stalls, rdf, rda, sw);
      vectors++;
      if (rdf !== exp_rd) begin
        miscompares++; $display("FAIL rand_rdata op%0d: got %08h, want %08h", i, rdf, exp_rd);
      end
      if (req && we) ref_mem[w] = data;
      else if (req) exp_rd = ref_mem[w];
    end
    do_op(1'b0, 1'b0, 32'h0, 32'h0, stalls, rdf, rda, sw);
    vectors++;
    if (rdf !== exp_rd) begin miscompares++; $display("FAIL rand_rdata_last: got %08h, want %08h", rdf, exp_rd); end
    ack_noise = 1'b0;
    rand_lat  = 1'b0;
    idle(12);
    for (int k = 8'hC0; k <= 8'hC7; k++) begin
      vectors++;
      if (bmem[k] !== ref_mem[k]) begin
        miscompares++; $display("FAIL rand_mem word %02h: got %08h, want %08h", k, bmem[k], ref_mem[k]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) bmem[i] = 32'h5A000000 + i;
    test_reset();
    test_load_latency();
`ifdef DMEM_WBUF_EN
    test_store_forward();
    test_back_to_back();
    test_store_on_ack();
`else
    test_store_nowbuf();
`endif
    test_reset_mid_load();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 The block SHALL have exactly these ports:
- clk  in  1  sole clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- MemReqM  in  1  Memory-stage access valid.
- MemWriteM  in  1  1 = store, 0 = load; qualified by MemReqM.
- ALUOutM  in  32  byte address from the Memory stage.
- WriteDataM  in  32  store data.
- ReadDataM  out  32  load data to the Writeback pipeline register.
- MemStallM  out  1  stalls the whole pipeline while high.
- mem_req  out  1  backing-memory request.
- mem_we  out  1  backing-memory write enable.
- mem_addr  out  32  backing-memory word address.
- mem_wdata  out  32  backing-memory write data.
- mem_ack  in  1  backing-memory completion.
- mem_rdata  in  32  read data, valid in the mem_ack cycle.

Function
REQ-002 The block SHALL implement a state machine with states IDLE, LOAD, STORE, DRAIN and RESP, plus a 1-entry write buffer: wb_valid, wb_addr and wb_data.
REQ-003 mem_addr SHALL equal {addr[31:2],2'b00}; addr[1:0] SHALL be ignored; all accesses are 32-bit words.
REQ-004 Backing handshake: mem_req, mem_we, mem_addr and mem_wdata SHALL be registered outputs, held stable from assertion until the cycle mem_ack=1 is sampled, then deasserted.
REQ-005 At most one backing transaction SHALL be outstanding; mem_ack with mem_req=0 SHALL be ignored.
REQ-006 Load in IDLE with no buffer hit: MemStallM=1 combinationally in that cycle, then go to LOAD and assert mem_req (mem_we=0) the following cycle.
REQ-007 LOAD behaviour:
- MemStallM SHALL stay 1.
- On mem_ack, mem_rdata SHALL be captured into ReadDataM and the next state SHALL be RESP.
REQ-008 RESP behaviour:
- MemStallM SHALL be 0.
- ReadDataM SHALL hold the captured data.
- The next state SHALL be IDLE; the still-present request SHALL NOT be reissued.
REQ-009 Minimum load latency: request cycle N, mem_ack at N+1, data and stall-low at N+2.
REQ-010 ReadDataM SHALL change only on a load capture or a buffer forward; otherwise it SHALL hold its last value.
REQ-011 Store with buffer empty (IDLE): captured into the write buffer, MemStallM=0, next state DRAIN; mem_req/mem_we=1 is asserted the following cycle.
REQ-012 Store while DRAIN with mem_ack=0: MemStallM=1.
REQ-013 Store in the DRAIN cycle where mem_ack=1: MemStallM=0, the buffer is reloaded with the new store, and the state remains DRAIN.
REQ-014 Load with wb_valid=1 and word address equal to wb_addr: ReadDataM=wb_data registered, MemStallM=0 in that cycle, with no backing access.
REQ-015 Load with wb_valid=1 and no address match: MemStallM=1 until the drain completes, then handled as in REQ-006.
REQ-016 DRAIN with mem_ack=1 and no new store: wb_valid SHALL clear and the next state SHALL be IDLE.
REQ-017 MemReqM=0 SHALL never cause a state change, except drain completion.

Reset
REQ-018 Reset low SHALL immediately force:
- state IDLE, wb_valid=0
- mem_req=0, mem_we=0, MemStallM=0
- ReadDataM, mem_addr and mem_wdata all 32'h0
REQ-019 Reset in any state SHALL abandon the outstanding access and discard any buffered store; an in-flight mem_ack after release SHALL be ignored per REQ-005.

Configuration
REQ-020 Macro DMEM_WBUF_EN: when defined, the write buffer behaviour of REQ-011 to REQ-016 SHALL be compiled in.
REQ-021 When DMEM_WBUF_EN is undefined, the block SHALL behave as follows:
- No buffer storage and no forwarding logic SHALL exist, and DRAIN SHALL be unused.
- A store in IDLE SHALL behave like a load: MemStallM=1, go to STORE, assert mem_req and mem_we=1.
- On mem_ack the next state SHALL be RESP; ReadDataM SHALL be unchanged.

Verification
REQ-022 The bench SHALL cover these scenarios:
- Reset release, then a load of 0x100 with mem_ack 3 cycles after mem_req -> MemStallM high 4 cycles; ReadDataM=mem_rdata (0xCAFEF00D) in the first cycle with MemStallM low; exactly one mem_req.
- DMEM_WBUF_EN: store 0xDEADBEEF to 0x204, then a load of 0x204 in the next cycle -> zero stall cycles; ReadDataM=0xDEADBEEF; one backing write to 0x204 only.
- DMEM_WBUF_EN: back-to-back stores to 0x10 and 0x14 with mem_ack delayed 2 cycles -> second store stalls 2 cycles; writes issued in order 0x10 then 0x14.
- DMEM_WBUF_EN: store in the cycle mem_ack=1 for the prior drain -> MemStallM=0; the new store is issued on the following cycle.
- Without DMEM_WBUF_EN: store to 0x8 with mem_ack after 1 cycle -> MemStallM high 2 cycles; mem_we=1; ReadDataM unchanged.
- Reset asserted mid-LOAD -> mem_req and MemStallM drop asynchronously; a late mem_ack after release produces no state change.
